counter_timer_chain: RTL and testbench
======================================

COUNTER_TIMER_CHAIN -- requirements
Module: counter_timer_chain

Interface
REQ-001 SHALL have port clkin, input, 1: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-003 SHALL have port reg_cfg_we, input, 4: byte-lane write enables for the config register (only lane 0 is meaningful).
REQ-004 SHALL have port reg_cfg_di, input, 32: config write data; bits [4:0] are used, upper bits are ignored.
REQ-005 SHALL have port reg_cfg_do, output, 32: config readback; bits [31:5] read zero.
REQ-006 SHALL have port reg_val_we, input, 4: byte-lane write enables for the limit/reload register.
REQ-007 SHALL have port reg_val_di, input, 32: limit/reload write data.
REQ-008 SHALL have port reg_val_do, output, 32: limit/reload readback.
REQ-009 SHALL have port reg_dat_we, input, 4: byte-lane write enables for the count register.
REQ-010 SHALL have port reg_dat_di, input, 32: count write data.
REQ-011 SHALL have port reg_dat_do, output, 32: current count readback.
REQ-012 SHALL have port chain_in, input, 1: advance qualifier from the lower-order stage.
REQ-013 SHALL have port chain_out, output, 1: one-cycle terminal-event strobe for the next stage.
REQ-014 SHALL have port irq_out, output, 1: one-cycle interrupt pulse.

Function
REQ-015 SHALL define the cfg bits as: bit0 = enable; bit1 = oneshot; bit2 = updown (1 = up, 0 = down); bit3 = irq_en; bit4 = chain.
REQ-016 SHALL write each 8-bit byte lane of cfg, val or dat only when its we bit is set.
REQ-017 SHALL reflect a register write on the corresponding *_do output on the cycle after the write edge.
REQ-018 SHALL define an advance cycle as enable=1 AND (chain=0 OR chain_in=1); no other cycle changes dat by counting.
REQ-019 SHALL, in down mode on an advance cycle: if dat != 0, set dat <= dat-1; if dat == 0 (terminal), reload dat <= val (periodic) or hold 0 and clear enable (oneshot).
REQ-020 SHALL, in up mode on an advance cycle: if dat != val, set dat <= dat+1; if dat == val (terminal), reload dat <= 0 (periodic) or hold val and clear enable (oneshot).
REQ-021 SHALL wrap arithmetic modulo 2^32: in up mode with dat > val, counting continues through 0xFFFFFFFF to 0 until it equals val.
REQ-022 SHALL register chain_out high for exactly one cycle, the cycle after a terminal advance cycle.
REQ-023 SHALL register irq_out = chain_out AND irq_en, so irq_out has the same timing as chain_out.
REQ-024 SHALL give a dat write priority over counting in the same cycle; the terminal test then uses the pre-write dat, but dat takes the written value.
REQ-025 SHALL, on a cfg write coinciding with a oneshot terminal cycle, apply the written cfg value; the enable auto-clear is discarded.
REQ-026 SHALL, on a val write during counting, use the new val from the next cycle onward for both the terminal compare and the reload.
REQ-027 SHALL, with val = 0 in periodic mode, produce a terminal event on every advance cycle, with dat staying 0.
REQ-028 SHALL, when enable is set by a write, make the first advance cycle the cycle after that write.

Reset
REQ-029 SHALL, while resetn=0 at a clock edge, clear cfg, val and dat to 0, drive chain_out and irq_out to 0, and discard any pending strobe.
REQ-030 SHALL, on reset asserted mid-count, suppress any terminal event on that edge; counting resumes only after cfg is rewritten.
REQ-031 SHALL ignore register writes on any edge where resetn=0.

Verification
REQ-032 SHALL cover down periodic: val=3, dat=3, cfg=0x09 -> dat reads 3,2,1,0,3,2 on successive cycles; irq_out pulses once per 4 cycles, the cycle after dat=0.
REQ-033 SHALL cover up oneshot: val=5, dat=0, cfg=0x07 -> dat runs 0..5 then holds 5; cfg_do reads 0x06; chain_out pulses once; irq_out stays 0.
REQ-034 SHALL cover a chained pair: low stage down periodic with val=1 feeding the high stage (chain_in <- low chain_out, cfg=0x11, val=2, dat=2) -> high dat decrements once per 2 clocks (2,1,0,2); high chain_out pulses every 6 clocks.
REQ-035 SHALL cover write collision: dat=0 down periodic, val=7, dat write of 0x12 on the terminal cycle -> dat=0x12 next cycle; chain_out still pulses.
REQ-036 SHALL cover reset mid-count: up periodic at dat=0x100, resetn low for one edge -> all *_do read 0; chain_out/irq_out stay 0; dat stays 0 after release.
REQ-037 SHALL cover byte lanes: val=0, write 0xDCBA7CFB with reg_val_we=4'b0101 -> val reads 0x00BA00FB.

Source files
------------

// File: rtl/counter_timer_chain.sv
// rtl/counter_timer_chain.sv - cascadable up/down counter-timer stage with byte-lane register writes
module counter_timer_chain (
  input  logic        clkin,
  input  logic        resetn,
  input  logic [3:0]  reg_cfg_we,
  input  logic [31:0] reg_cfg_di,
  output logic [31:0] reg_cfg_do,
  input  logic [3:0]  reg_val_we,
  input  logic [31:0] reg_val_di,
  output logic [31:0] reg_val_do,
  input  logic [3:0]  reg_dat_we,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  input  logic        chain_in,
  output logic        chain_out,
  output logic        irq_out
);

  localparam int CFG_ENABLE  = 0;
  localparam int CFG_ONESHOT = 1;
  localparam int CFG_UPDOWN  = 2;
  localparam int CFG_IRQ_EN  = 3;
  localparam int CFG_CHAIN   = 4;

  logic [4:0]  cfg_q, cfg_d;
  logic [31:0] val_q, val_d;
  logic [31:0] dat_q, dat_d;
  logic        chain_out_q, chain_out_d;
  logic        irq_out_q, irq_out_d;

  logic        advance;
  logic        at_terminal;
  logic        terminal_event;
  logic        enable_clear;
  logic [31:0] count_next;

  // Only lane 0 of the config register carries state; the rest is accepted and dropped.
  logic        cfg_unused;
  assign cfg_unused = ^{reg_cfg_we[3:1], reg_cfg_di[31:5]};

  // Replace each byte of cur with the matching byte of wdata where its lane enable is set.
  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  we);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        res[i*8 +: 8] = wdata[i*8 +: 8];
      end
    end
    return res;
  endfunction

  // Decide whether this cycle counts and whether the count sits at its terminal value.
  always_comb begin
    advance        = cfg_q[CFG_ENABLE] & (~cfg_q[CFG_CHAIN] | chain_in);
    at_terminal    = cfg_q[CFG_UPDOWN] ? (dat_q == val_q) : (dat_q == 32'd0);
    terminal_event = advance & at_terminal;
  end

  // Counting step: step toward the terminal, then reload (periodic) or park and stop (oneshot).
  always_comb begin
    count_next   = dat_q;
    enable_clear = 1'b0;
    if (advance) begin
      if (!at_terminal) begin
        count_next = cfg_q[CFG_UPDOWN] ? dat_q + 32'd1 : dat_q - 32'd1;
      end else if (cfg_q[CFG_ONESHOT]) begin
        // dat already equals the parking value (val when up, 0 when down).
        count_next   = dat_q;
        enable_clear = 1'b1;
      end else begin
        count_next = cfg_q[CFG_UPDOWN] ? 32'd0 : val_q;
      end
    end
  end

  // Register next-state: software writes override the counter's own updates lane by lane.
  always_comb begin
    cfg_d = cfg_q;
    if (enable_clear) begin
      cfg_d[CFG_ENABLE] = 1'b0;
    end
    if (reg_cfg_we[0]) begin
      cfg_d = reg_cfg_di[4:0];
    end
    val_d       = merge_lanes(val_q, reg_val_di, reg_val_we);
    dat_d       = merge_lanes(count_next, reg_dat_di, reg_dat_we);
    chain_out_d = terminal_event;
    irq_out_d   = terminal_event & cfg_q[CFG_IRQ_EN];
  end

  // State registers with synchronous active-low reset; reset also blocks writes and strobes.
  always_ff @(posedge clkin) begin
    if (!resetn) begin
      cfg_q       <= 5'd0;
      val_q       <= 32'd0;
      dat_q       <= 32'd0;
      chain_out_q <= 1'b0;
      irq_out_q   <= 1'b0;
    end else begin
      cfg_q       <= cfg_d;
      val_q       <= val_d;
      dat_q       <= dat_d;
      chain_out_q <= chain_out_d;
      irq_out_q   <= irq_out_d;
    end
  end

  assign reg_cfg_do = {27'd0, cfg_q};
  assign reg_val_do = val_q;
  assign reg_dat_do = dat_q;
  assign chain_out  = chain_out_q;
  assign irq_out    = irq_out_q;

endmodule

// File: tb/tb_counter_timer_chain.sv
// tb/tb_counter_timer_chain.sv - directed self-checking bench for counter_timer_chain
module tb_counter_timer_chain;

  logic        clkin;
  logic        resetn;
  logic [3:0]  reg_cfg_we, reg_val_we, reg_dat_we;
  logic [31:0] reg_cfg_di, reg_val_di, reg_dat_di;
  logic [31:0] reg_cfg_do, reg_val_do, reg_dat_do;
  logic        chain_in_tb, chain_sel, chain_in, chain_out, irq_out;

  logic [3:0]  lo_cfg_we, lo_val_we, lo_dat_we;
  logic [31:0] lo_cfg_di, lo_val_di, lo_dat_di;
  logic [31:0] lo_cfg_do, lo_val_do, lo_dat_do;
  logic        lo_chain_out, lo_irq_out;

  int tests_run;
  int tests_failed;

  assign chain_in = chain_sel ? lo_chain_out : chain_in_tb;

  counter_timer_chain u_dut (
    .clkin      (clkin),
    .resetn     (resetn),
    .reg_cfg_we (reg_cfg_we),
    .reg_cfg_di (reg_cfg_di),
    .reg_cfg_do (reg_cfg_do),
    .reg_val_we (reg_val_we),
    .reg_val_di (reg_val_di),
    .reg_val_do (reg_val_do),
    .reg_dat_we (reg_dat_we),
    .reg_dat_di (reg_dat_di),
    .reg_dat_do (reg_dat_do),
    .chain_in   (chain_in),
    .chain_out  (chain_out),
    .irq_out    (irq_out)
  );

  counter_timer_chain u_lo (
    .clkin      (clkin),
    .resetn     (resetn),
    .reg_cfg_we (lo_cfg_we),
    .reg_cfg_di (lo_cfg_di),
    .reg_cfg_do (lo_cfg_do),
    .reg_val_we (lo_val_we),
    .reg_val_di (lo_val_di),
    .reg_val_do (lo_val_do),
    .reg_dat_we (lo_dat_we),
    .reg_dat_di (lo_dat_di),
    .reg_dat_do (lo_dat_do),
    .chain_in   (1'b0),
    .chain_out  (lo_chain_out),
    .irq_out    (lo_irq_out)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic set_regs(input logic wc, input logic [31:0] c,
                          input logic wv, input logic [31:0] v,
                          input logic wd, input logic [31:0] d);
    reg_cfg_we = wc ? 4'hF : 4'h0;
    reg_cfg_di = c;
    reg_val_we = wv ? 4'hF : 4'h0;
    reg_val_di = v;
    reg_dat_we = wd ? 4'hF : 4'h0;
    reg_dat_di = d;
    tick();
    reg_cfg_we = 4'h0;
    reg_val_we = 4'h0;
    reg_dat_we = 4'h0;
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    reg_cfg_we = 4'hF; reg_cfg_di = 32'h0000_001F;
    reg_val_we = 4'hF; reg_val_di = 32'h1234_5678;
    reg_dat_we = 4'hF; reg_dat_di = 32'h8765_4321;
    tick();
    tick();
    reg_cfg_we = 4'h0; reg_val_we = 4'h0; reg_dat_we = 4'h0;
    tests_run++;
    if ({reg_cfg_do, reg_val_do, reg_dat_do} !== 96'd0) begin
      tests_failed++;
      $display("FAIL reset_regs: got cfg=%h val=%h dat=%h, expected all 0", reg_cfg_do, reg_val_do, reg_dat_do);
    end
    tests_run++;
    if ({chain_out, irq_out} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_strobes: got chain=%b irq=%b, expected 0 0", chain_out, irq_out);
    end
    resetn = 1'b1;
    tick();
    tests_run++;
    if (reg_dat_do !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_release_dat: got %h expected 0", reg_dat_do);
    end
  endtask

  task automatic test_down_periodic();
    int exp_dat [9] = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
    int exp_irq [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    set_regs(1'b1, 32'h09, 1'b1, 32'd3, 1'b1, 32'd3);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      tests_run++;
      if (reg_dat_do !== 32'(exp_dat[i])) begin
        tests_failed++;
        $display("FAIL down_periodic_dat[%0d]: got %h expected %h", i, reg_dat_do, exp_dat[i]);
      end
      tests_run++;
      if (irq_out !== 1'(exp_irq[i]) || chain_out !== 1'(exp_irq[i])) begin
        tests_failed++;
        $display("FAIL down_periodic_strobe[%0d]: got irq=%b chain=%b expected %0d", i, irq_out, chain_out, exp_irq[i]);
      end
    end
  endtask

  task automatic test_up_oneshot();
    int exp_dat [9] = '{0, 1, 2, 3, 4, 5, 5, 5, 5};
    int exp_chn [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    do_reset();
    set_regs(1'b1, 32'h07, 1'b1, 32'd5, 1'b1, 32'd0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      tests_run++;
      if (reg_dat_do !== 32'(exp_dat[i])) begin
        tests_failed++;
        $display("FAIL up_oneshot_dat[%0d]: got %h expected %h", i, reg_dat_do, exp_dat[i]);
      end
      tests_run++;
      if (chain_out !== 1'(exp_chn[i]) || irq_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL up_oneshot_strobe[%0d]: got chain=%b irq=%b expected chain=%0d irq=0", i, chain_out, irq_out, exp_chn[i]);
      end
    end
    tests_run++;
    if (reg_cfg_do !== 32'h06) begin
      tests_failed++;
      $display("FAIL up_oneshot_cfg: got %h expected 00000006", reg_cfg_do);
    end
  endtask

  task automatic test_chain();
    int exp_dat [14] = '{2, 2, 2, 1, 1, 0, 0, 2, 2, 1, 1, 0, 0, 2};
    int exp_chn [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    do_reset();
    chain_sel = 1'b1;
    lo_cfg_we = 4'hF; lo_cfg_di = 32'h01;
    lo_val_we = 4'hF; lo_val_di = 32'd1;
    lo_dat_we = 4'hF; lo_dat_di = 32'd1;
    set_regs(1'b1, 32'h11, 1'b1, 32'd2, 1'b1, 32'd2);
    lo_cfg_we = 4'h0; lo_val_we = 4'h0; lo_dat_we = 4'h0;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) tick();
      tests_run++;
      if (reg_dat_do !== 32'(exp_dat[i])) begin
        tests_failed++;
        $display("FAIL chain_hi_dat[%0d]: got %h expected %h", i, reg_dat_do, exp_dat[i]);
      end
      tests_run++;
      if (chain_out !== 1'(exp_chn[i])) begin
        tests_failed++;
        $display("FAIL chain_hi_out[%0d]: got %b expected %0d", i, chain_out, exp_chn[i]);
      end
    end
    chain_sel = 1'b0;
  endtask

  task automatic test_collision();
    do_reset();
    set_regs(1'b1, 32'h09, 1'b1, 32'd7, 1'b1, 32'd0);
    set_regs(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h12);
    tests_run++;
    if (reg_dat_do !== 32'h12 || chain_out !== 1'b1 || irq_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL collision_dat_write: got dat=%h chain=%b irq=%b expected 12 1 1", reg_dat_do, chain_out, irq_out);
    end
    tick();
    tests_run++;
    if (reg_dat_do !== 32'h11 || chain_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL collision_after: got dat=%h chain=%b expected 11 0", reg_dat_do, chain_out);
    end
    do_reset();
    set_regs(1'b1, 32'h03, 1'b1, 32'd7, 1'b1, 32'd0);
    set_regs(1'b1, 32'h0B, 1'b0, 32'h0, 1'b0, 32'h0);
    tests_run++;
    if (reg_cfg_do !== 32'h0B || chain_out !== 1'b1 || reg_dat_do !== 32'd0) begin
      tests_failed++;
      $display("FAIL collision_cfg_write: got cfg=%h chain=%b dat=%h expected 0b 1 0", reg_cfg_do, chain_out, reg_dat_do);
    end
    tick();
    tests_run++;
    if (reg_cfg_do !== 32'h0A || chain_out !== 1'b1 || irq_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL collision_oneshot_clear: got cfg=%h chain=%b irq=%b expected 0a 1 1", reg_cfg_do, chain_out, irq_out);
    end
  endtask

  task automatic test_val_edges();
    do_reset();
    set_regs(1'b1, 32'h09, 1'b1, 32'd0, 1'b1, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (reg_dat_do !== 32'd0 || chain_out !== 1'b1 || irq_out !== 1'b1) begin
        tests_failed++;
        $display("FAIL val_zero[%0d]: got dat=%h chain=%b irq=%b expected 0 1 1", i, reg_dat_do, chain_out, irq_out);
      end
    end
    do_reset();
    set_regs(1'b1, 32'h05, 1'b1, 32'd10, 1'b1, 32'd3);
    set_regs(1'b0, 32'h0, 1'b1, 32'd4, 1'b0, 32'h0);
    tests_run++;
    if (reg_dat_do !== 32'd4 || chain_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL val_write_same_cycle: got dat=%h chain=%b expected 4 0", reg_dat_do, chain_out);
    end
    tick();
    tests_run++;
    if (reg_dat_do !== 32'd0 || chain_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL val_write_next_cycle: got dat=%h chain=%b expected 0 1", reg_dat_do, chain_out);
    end
    do_reset();
    set_regs(1'b1, 32'h05, 1'b1, 32'd1, 1'b1, 32'hFFFF_FFFE);
    begin
      logic [31:0] exp_w [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0};
      for (int i = 0; i < 5; i++) begin
        if (i > 0) tick();
        tests_run++;
        if (reg_dat_do !== exp_w[i] || chain_out !== (i == 4)) begin
          tests_failed++;
          $display("FAIL up_wrap[%0d]: got dat=%h chain=%b expected %h %0d", i, reg_dat_do, chain_out, exp_w[i], (i == 4));
        end
      end
    end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    set_regs(1'b1, 32'h0D, 1'b1, 32'h100, 1'b1, 32'hFF);
    tick();
    tests_run++;
    if (reg_dat_do !== 32'h100) begin
      tests_failed++;
      $display("FAIL midcount_pre: got %h expected 00000100", reg_dat_do);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tests_run++;
    if ({reg_cfg_do, reg_val_do, reg_dat_do} !== 96'd0 || chain_out !== 1'b0 || irq_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL midcount_reset: got cfg=%h val=%h dat=%h chain=%b irq=%b expected all 0", reg_cfg_do, reg_val_do, reg_dat_do, chain_out, irq_out);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (reg_dat_do !== 32'd0 || chain_out !== 1'b0 || irq_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL midcount_release[%0d]: got dat=%h chain=%b irq=%b expected 0 0 0", i, reg_dat_do, chain_out, irq_out);
      end
    end
  endtask

  task automatic test_byte_lanes();
    do_reset();
    reg_val_we = 4'b0101;
    reg_val_di = 32'hDCBA_7CFB;
    reg_dat_we = 4'b1000;
    reg_dat_di = 32'h1122_3344;
    reg_cfg_we = 4'b1110;
    reg_cfg_di = 32'hFFFF_FFFF;
    tick();
    reg_val_we = 4'h0; reg_dat_we = 4'h0; reg_cfg_we = 4'h0;
    tests_run++;
    if (reg_val_do !== 32'h00BA_00FB) begin
      tests_failed++;
      $display("FAIL byte_lane_val: got %h expected 00ba00fb", reg_val_do);
    end
    tests_run++;
    if (reg_dat_do !== 32'h1100_0000) begin
      tests_failed++;
      $display("FAIL byte_lane_dat: got %h expected 11000000", reg_dat_do);
    end
    tests_run++;
    if (reg_cfg_do !== 32'd0) begin
      tests_failed++;
      $display("FAIL byte_lane_cfg_upper: got %h expected 0", reg_cfg_do);
    end
    reg_cfg_we = 4'b0001;
    reg_cfg_di = 32'hFFFF_FFE2;
    tick();
    reg_cfg_we = 4'h0;
    tests_run++;
    if (reg_cfg_do !== 32'h02) begin
      tests_failed++;
      $display("FAIL byte_lane_cfg_low: got %h expected 00000002", reg_cfg_do);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    resetn       = 1'b0;
    chain_sel    = 1'b0;
    chain_in_tb  = 1'b0;
    reg_cfg_we = 4'h0; reg_cfg_di = 32'h0;
    reg_val_we = 4'h0; reg_val_di = 32'h0;
    reg_dat_we = 4'h0; reg_dat_di = 32'h0;
    lo_cfg_we  = 4'h0; lo_cfg_di  = 32'h0;
    lo_val_we  = 4'h0; lo_val_di  = 32'h0;
    lo_dat_we  = 4'h0; lo_dat_di  = 32'h0;
    test_reset();
    test_down_periodic();
    test_up_oneshot();
    test_chain();
    test_collision();
    test_val_edges();
    test_reset_midcount();
    test_byte_lanes();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
